ram_modport: RTL and testbench



---
 rtl/ram_modport.sv | 71 +++++++
 tb/tb_ram_modport.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_modport.sv
// ---------------------------------------------------------------------------
// ram_modport
//
// Simple dual-port synchronous RAM: one write port and one read port with
// independent addresses. Both ports are gated by a shared chip select. Read
// data is registered, so it appears one cycle after the edge that sampled
// the read request.
//
// Ports:
//   clk    in   1           single clock, all actions on the rising edge
//   rst    in   1           synchronous, active-high reset. Clears rdata and
//                           every memory word, and overrides cs/wen/ren
//   cs     in   1           chip select. When low, neither port has effect
//   wen    in   1           write enable
//   ren    in   1           read enable
//   waddr  in   ADDR_WIDTH  write address
//   wdata  in   DATA_WIDTH  write data (stored exactly)
//   raddr  in   ADDR_WIDTH  read address
//   rdata  out  DATA_WIDTH  registered read data. Holds its value when idle
//
// A read and a write to the same address in the same cycle return the old
// contents (read-before-write). The new value is visible to the next read.
// ---------------------------------------------------------------------------
module ram_modport #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wr_fire;
    logic rd_fire;

    // Each port takes effect only when it is enabled and the chip is selected.
    // Reset is handled in the sequential block and takes priority there.
    assign wr_fire = cs & wen;
    assign rd_fire = cs & ren;

    // NOTE: this memory must be cleared in a single reset cycle. That rules
    // out a RAM macro, so the array is built from flops with a reset. The
    // non-blocking assignments give read-before-write with no bypass logic:
    // the read samples mem[raddr] before the write commits at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (rd_fire) begin
                rdata <= mem[raddr];
            end
            if (wr_fire) begin
                mem[waddr] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_modport.sv
// ---------------------------------------------------------------------------
// tb_ram_modport
//
// Scoreboard bench for ram_modport. The stimulus process drives one request
// per cycle on the falling edge. It advances a behavioural model of the RAM
// and pushes the rdata value expected after the next rising edge onto a
// queue. A separate monitor pops that queue 1 ns after each rising edge and
// compares the entry with the DUT.
// ---------------------------------------------------------------------------
module tb_ram_modport;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cs = 1'b0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] rdata;

    ram_modport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .wen   (wen),
        .ren   (ren),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    // Behavioural model: an array of words plus the last read result.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rdata;

    int    vectors     = 0;
    int    miscompares = 0;
    string phase       = "idle";
    bit    stim_done   = 1'b0;

    // Drive one cycle of requests and record the rdata expected after it.
    task automatic step(input logic r, input logic c, input logic we,
                        input logic re, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        sb_entry_t e;
        @(negedge clk);
        rst   = r;
        cs    = c;
        wen   = we;
        ren   = re;
        waddr = wa;
        wdata = wd;
        raddr = ra;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            ref_rdata = '0;
        end else begin
            // The read sees the contents before this cycle's write.
            if (c && re) ref_rdata = ref_mem[ra];
            if (c && we) ref_mem[wa] = wd;
        end
        e.tag = phase;
        e.exp = ref_rdata;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b0, 1'b1, 1'b1, 1'b0, a, d, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, a);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: rdata=0x%02h expected=0x%02h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: one rdata value is due after every rising edge that follows
    // a driven cycle.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.tag, rdata, e.exp);
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: stim_done=%0d required=1", stim_done);
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;

        // Reset sanity. The second reset cycle also presents a write and a
        // read, which reset must override.
        phase = "reset";
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 8'hAB, 4'd1);
        phase = "reset_read";
        rd(4'd0);
        rd(4'd5);
        rd(4'd15);
        rd(4'd1);

        phase = "write_read";
        wr(4'd3, 8'hA5);
        rd(4'd3);

        // Chip select gating on both ports, and hold when ren is low.
        phase = "cs_write_gated";
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 8'h3C, '0);
        rd(4'd7);
        phase = "cs_read_hold";
        rd(4'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 4'd7);
        phase = "ren_low_hold";
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 4'd7);
        idle();

        // Same-address read and write in one cycle returns the old value.
        phase = "same_addr";
        wr(4'd2, 8'h11);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 8'h22, 4'd2);
        rd(4'd2);
        phase = "diff_addr";
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 8'h66, 4'd3);
        rd(4'd6);

        phase = "sweep";
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i) ^ 8'hFF);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));

        // Reset mid-stream discards the write presented with it.
        phase = "reset_mid";
        wr(4'd9, 8'h77);
        rd(4'd9);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 8'h55, 4'd9);
        rd(4'd9);
        rd(4'd4);

        // Random traffic. Addresses often collide, and reset is occasional.
        phase = "random";
        for (int n = 0; n < 600; n++) begin
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 4) != 0),
                 1'($urandom), 1'($urandom),
                 wa, DW'($urandom), ra);
        end

        phase = "drain";
        idle();
        repeat (3) @(posedge clk);
        #2;
        stim_done = 1'b1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
